// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types, CSR bit positions and trap priority tables
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_RET,
    ST_REDIRECT
  } trap_state_e;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [3:0] CAUSE_INST_MISALIGN  = 4'd0;
  localparam logic [3:0] CAUSE_INST_FAULT     = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL_INST   = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_U        = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_S        = 4'd9;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
  localparam logic [3:0] CAUSE_INST_PAGE      = 4'd12;
  localparam logic [3:0] CAUSE_LOAD_PAGE      = 4'd13;
  localparam logic [3:0] CAUSE_STORE_PAGE     = 4'd15;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // Nibble 0 holds the highest-priority exception cause.
  localparam int unsigned EXC_PRIO_NUM = 14;
  localparam logic [63:0] EXC_PRIO_ORDER = {
    8'h00,
    CAUSE_STORE_FAULT, CAUSE_LOAD_FAULT, CAUSE_STORE_PAGE, CAUSE_LOAD_PAGE,
    CAUSE_STORE_MISALIGN, CAUSE_LOAD_MISALIGN, CAUSE_ECALL_M, CAUSE_ECALL_S,
    CAUSE_ECALL_U, CAUSE_ILLEGAL_INST, CAUSE_INST_MISALIGN, CAUSE_INST_FAULT,
    CAUSE_INST_PAGE, CAUSE_BREAKPOINT
  };

  typedef enum logic [1:0] {
    MTVAL_ZERO,
    MTVAL_PC,
    MTVAL_INST,
    MTVAL_ADDR
  } mtval_src_e;

  function automatic mtval_src_e mtval_src(input logic [3:0] code);
    case (code)
      CAUSE_INST_MISALIGN, CAUSE_INST_FAULT, CAUSE_INST_PAGE: return MTVAL_PC;
      CAUSE_ILLEGAL_INST:                                      return MTVAL_INST;
      CAUSE_LOAD_MISALIGN, CAUSE_LOAD_FAULT, CAUSE_STORE_MISALIGN,
      CAUSE_STORE_FAULT, CAUSE_LOAD_PAGE, CAUSE_STORE_PAGE:    return MTVAL_ADDR;
      default:                                                 return MTVAL_ZERO;
    endcase
  endfunction

  // Highest interrupt line first, so MEI > MTI > MSI falls out naturally.
  function automatic logic [63:0] irq_prio_order(input int unsigned num);
    logic [63:0] ord;
    ord = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < num) ord[i*4 +: 4] = 4'(num - 1 - i);
    end
    return ord;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - ordered priority encoder over a table of cause codes
module trap_prio_enc #(
  parameter int unsigned NUM   = 16,
  parameter logic [63:0] ORDER = 64'h0
) (
  input  logic [15:0] req_i,
  output logic        valid_o,
  output logic [3:0]  code_o
);

  // Walk from lowest to highest priority so the first table entry wins.
  always_comb begin
    valid_o = 1'b0;
    code_o  = 4'd0;
    for (int i = int'(NUM) - 1; i >= 0; i--) begin
      if (req_i[ORDER[i*4 +: 4]]) begin
        valid_o = 1'b1;
        code_o  = ORDER[i*4 +: 4];
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer at the commit point
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NUM_IRQ = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                commit_valid,
  input  logic [XLEN-1:0]     commit_pc,
  input  logic [31:0]         commit_inst,
  input  logic [15:0]         commit_excp,
  input  logic                commit_mret,
  input  logic [XLEN-1:0]     mem_addr,
  input  logic [NUM_IRQ-1:0]  irq_pending,
  input  logic [XLEN-1:0]     mie_rd,
  input  logic [XLEN-1:0]     mstatus_rd,
  input  logic [XLEN-1:0]     mtvec_rd,
  input  logic [XLEN-1:0]     mepc_rd,
  output logic                csr_wen,
  output logic [XLEN-1:0]     mcause_wd,
  output logic [XLEN-1:0]     mepc_wd,
  output logic [XLEN-1:0]     mtval_wd,
  output logic [XLEN-1:0]     mstatus_wd,
  output logic                flush,
  output logic                busy,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  input  logic                redirect_ready
);

  trap_state_e     state_q;
  logic            csr_wen_q, flush_q, busy_q, redirect_valid_q;
  logic [XLEN-1:0] mcause_q, mepc_q, mtval_q, mstatus_q, redirect_pc_q;

  logic [15:0]     irq_vec;
  logic            irq_valid, exc_valid, is_irq, take_trap, take_ret;
  logic [3:0]      irq_code, exc_code, code;
  logic [XLEN-1:0] mcause_d, mtval_d, mstatus_entry_d, mstatus_ret_d;
  logic [XLEN-1:0] trap_base, trap_pc_d, ret_pc_d;
  logic            unused_bits;

  assign unused_bits = ^{mie_rd[XLEN-1:NUM_IRQ], mepc_rd[1:0]};

  always_comb begin
    irq_vec = '0;
    irq_vec[NUM_IRQ-1:0] = irq_pending & mie_rd[NUM_IRQ-1:0]
                         & {NUM_IRQ{mstatus_rd[MSTATUS_MIE]}};
  end

  trap_prio_enc #(.NUM(NUM_IRQ), .ORDER(irq_prio_order(NUM_IRQ))) u_irq_enc (
    .req_i   (irq_vec),
    .valid_o (irq_valid),
    .code_o  (irq_code)
  );

  trap_prio_enc #(.NUM(EXC_PRIO_NUM), .ORDER(EXC_PRIO_ORDER)) u_exc_enc (
    .req_i   (commit_excp),
    .valid_o (exc_valid),
    .code_o  (exc_code)
  );

  assign is_irq    = irq_valid;
  assign code      = irq_valid ? irq_code : exc_code;
  assign take_trap = commit_valid & ~busy_q & (irq_valid | exc_valid);
  assign take_ret  = commit_valid & ~busy_q & ~irq_valid & ~exc_valid & commit_mret;

  assign mcause_d  = {is_irq, (XLEN-1)'(code)};
  assign trap_base = {mtvec_rd[XLEN-1:2], 2'b00};
  assign trap_pc_d = (is_irq && mtvec_rd[1:0] == 2'b01)
                   ? trap_base + (XLEN'(code) << 2) : trap_base;
  assign ret_pc_d  = {mepc_rd[XLEN-1:2], 2'b00};

  always_comb begin
    mtval_d = '0;
    if (!is_irq) begin
      case (mtval_src(code))
        MTVAL_PC:   mtval_d = commit_pc;
        MTVAL_INST: mtval_d = XLEN'(commit_inst);
        MTVAL_ADDR: mtval_d = mem_addr;
        default:    mtval_d = '0;
      endcase
    end
  end

  always_comb begin
    mstatus_entry_d = mstatus_rd;
    mstatus_entry_d[MSTATUS_MPIE] = mstatus_rd[MSTATUS_MIE];
    mstatus_entry_d[MSTATUS_MIE]  = 1'b0;
    mstatus_entry_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_ret_d = mstatus_rd;
    mstatus_ret_d[MSTATUS_MIE]  = mstatus_rd[MSTATUS_MPIE];
    mstatus_ret_d[MSTATUS_MPIE] = 1'b1;
    mstatus_ret_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // On mret only mstatus is meaningful; the other write data keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      csr_wen_q        <= 1'b0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      mcause_q         <= '0;
      mepc_q           <= '0;
      mtval_q          <= '0;
      mstatus_q        <= '0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_trap) begin
            state_q       <= ST_ENTER;
            csr_wen_q     <= 1'b1;
            flush_q       <= 1'b1;
            busy_q        <= 1'b1;
            mcause_q      <= mcause_d;
            mepc_q        <= commit_pc;
            mtval_q       <= mtval_d;
            mstatus_q     <= mstatus_entry_d;
            redirect_pc_q <= trap_pc_d;
          end else if (take_ret) begin
            state_q       <= ST_RET;
            csr_wen_q     <= 1'b1;
            flush_q       <= 1'b1;
            busy_q        <= 1'b1;
            mstatus_q     <= mstatus_ret_d;
            redirect_pc_q <= ret_pc_d;
          end
        end
        ST_ENTER, ST_RET: begin
          state_q          <= ST_REDIRECT;
          csr_wen_q        <= 1'b0;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b1;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign csr_wen        = csr_wen_q;
  assign flush          = flush_q;
  assign busy           = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mcause_wd      = mcause_q;
  assign mepc_wd        = mepc_q;
  assign mtval_wd       = mtval_q;
  assign mstatus_wd     = mstatus_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;

  localparam int XLEN    = 64;
  localparam int NUM_IRQ = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               commit_valid, commit_mret, redirect_ready;
  logic [XLEN-1:0]    commit_pc, mem_addr, mie_rd, mstatus_rd, mtvec_rd, mepc_rd;
  logic [31:0]        commit_inst;
  logic [15:0]        commit_excp;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               csr_wen, flush, busy, redirect_valid;
  logic [XLEN-1:0]    mcause_wd, mepc_wd, mtval_wd, mstatus_wd, redirect_pc;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_excp(commit_excp), .commit_mret(commit_mret), .mem_addr(mem_addr),
    .irq_pending(irq_pending), .mie_rd(mie_rd), .mstatus_rd(mstatus_rd),
    .mtvec_rd(mtvec_rd), .mepc_rd(mepc_rd),
    .csr_wen(csr_wen), .mcause_wd(mcause_wd), .mepc_wd(mepc_wd),
    .mtval_wd(mtval_wd), .mstatus_wd(mstatus_wd), .flush(flush), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [15:0] excp;
    logic        mret;
    logic [63:0] addr;
    logic [15:0] irq;
    logic [63:0] mie, mstatus, mtvec, mepc;
    int          kind;  // 0 nothing, 1 trap, 2 mret
    logic [63:0] e_mcause, e_mepc, e_mtval, e_mstatus, e_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exc_prio [14] = '{3, 12, 1, 0, 2, 8, 9, 11, 4, 6, 13, 15, 5, 7};
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
      input logic [63:0] pc, input logic [31:0] inst, input logic [15:0] excp,
      input logic mret, input logic [63:0] addr, input logic [15:0] irq,
      input logic [63:0] mie, input logic [63:0] mstatus, input logic [63:0] mtvec,
      input logic [63:0] mepc, input int kind, input logic [63:0] e_mcause,
      input logic [63:0] e_mepc, input logic [63:0] e_mtval,
      input logic [63:0] e_mstatus, input logic [63:0] e_pc);
    vec_t v;
    v.pc = pc; v.inst = inst; v.excp = excp; v.mret = mret; v.addr = addr;
    v.irq = irq; v.mie = mie; v.mstatus = mstatus; v.mtvec = mtvec; v.mepc = mepc;
    v.kind = kind; v.e_mcause = e_mcause; v.e_mepc = e_mepc; v.e_mtval = e_mtval;
    v.e_mstatus = e_mstatus; v.e_pc = e_pc;
    return v;
  endfunction

  // Reference model: straight from the architectural rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int icode, ecode;
    logic [15:0] elig;
    r = v; icode = -1; ecode = -1;
    elig = v.mstatus[3] ? (v.irq & v.mie[15:0]) : 16'h0;
    for (int i = 0; i < 16; i++) if (elig[i]) icode = i;
    for (int k = 13; k >= 0; k--) if (v.excp[exc_prio[k]]) ecode = exc_prio[k];
    r.e_mcause = 0; r.e_mepc = 0; r.e_mtval = 0; r.e_pc = 0; r.e_mstatus = v.mstatus;
    if (icode >= 0 || ecode >= 0) begin
      r.kind = 1;
      r.e_mepc = v.pc;
      if (icode >= 0) begin
        r.e_mcause = 64'h8000_0000_0000_0000 + 64'(icode);
        r.e_pc = (v.mtvec[1:0] == 2'b01) ? (v.mtvec & ~64'h3) + 64'(4 * icode)
                                         : (v.mtvec & ~64'h3);
      end else begin
        r.e_mcause = 64'(ecode);
        if (ecode inside {0, 1, 12})                r.e_mtval = v.pc;
        else if (ecode == 2)                        r.e_mtval = {32'h0, v.inst};
        else if (ecode inside {4, 5, 6, 7, 13, 15}) r.e_mtval = v.addr;
        r.e_pc = v.mtvec & ~64'h3;
      end
      r.e_mstatus[7] = v.mstatus[3];
      r.e_mstatus[3] = 1'b0;
      r.e_mstatus[12:11] = 2'b11;
    end else if (v.mret) begin
      r.kind = 2;
      r.e_mstatus[3] = v.mstatus[7];
      r.e_mstatus[7] = 1'b1;
      r.e_mstatus[12:11] = 2'b11;
      r.e_pc = v.mepc & ~64'h3;
    end else begin
      r.kind = 0;
    end
    return r;
  endfunction

  task automatic apply(input vec_t v);
    commit_pc = v.pc; commit_inst = v.inst; commit_excp = v.excp; commit_mret = v.mret;
    mem_addr = v.addr; irq_pending = v.irq; mie_rd = v.mie; mstatus_rd = v.mstatus;
    mtvec_rd = v.mtvec; mepc_rd = v.mepc;
  endtask

  task automatic scramble();
    commit_pc = {$urandom, $urandom}; commit_inst = $urandom;
    commit_excp = 16'($urandom); commit_mret = 1'($urandom);
    mem_addr = {$urandom, $urandom}; irq_pending = 16'($urandom);
    mie_rd = {$urandom, $urandom}; mstatus_rd = {$urandom, $urandom};
    mtvec_rd = {$urandom, $urandom}; mepc_rd = {$urandom, $urandom};
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle.
  task automatic run_vec(input vec_t v, input int delay, input bit hold);
    apply(v);
    commit_valid = 1'b1;
    redirect_ready = 1'b0;
    @(posedge clk); #1;
    commit_valid = hold;
    scramble();
    @(negedge clk);
    if (v.kind == 0) begin
      chk("no_trap_busy", busy, 0);
      chk("no_trap_wen", csr_wen, 0);
      commit_valid = 1'b0;
      return;
    end
    chk("c1_csr_wen", csr_wen, 1);
    chk("c1_flush", flush, 1);
    chk("c1_busy", busy, 1);
    chk("c1_redirect_valid", redirect_valid, 0);
    chk("mstatus_wd", mstatus_wd, v.e_mstatus);
    if (v.kind == 1) begin
      chk("mcause_wd", mcause_wd, v.e_mcause);
      chk("mepc_wd", mepc_wd, v.e_mepc);
      chk("mtval_wd", mtval_wd, v.e_mtval);
    end
    @(negedge clk);
    chk("c2_csr_wen", csr_wen, 0);
    chk("c2_flush", flush, 0);
    chk("c2_redirect_valid", redirect_valid, 1);
    chk("c2_redirect_pc", redirect_pc, v.e_pc);
    chk("c2_busy", busy, 1);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("stall_redirect_valid", redirect_valid, 1);
      chk("stall_redirect_pc", redirect_pc, v.e_pc);
      chk("stall_busy", busy, 1);
      chk("stall_csr_wen", csr_wen, 0);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    commit_valid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_redirect_valid", redirect_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; commit_valid = 1'b0; redirect_ready = 1'b0;
    commit_pc = '0; commit_inst = '0; commit_excp = '0; commit_mret = 1'b0;
    mem_addr = '0; irq_pending = '0; mie_rd = '0; mstatus_rd = '0;
    mtvec_rd = '0; mepc_rd = '0;

    tbl[0]  = mkv(64'h8000_0100, 32'h13, 16'h0, 0, 0, 16'h0880, 64'h888, 64'h8, 64'h8000_0001, 0,
                  1, 64'h8000_0000_0000_000B, 64'h8000_0100, 0, 64'h1880, 64'h8000_002C);
    tbl[1]  = mkv(64'h4000, 32'hFFFF_FFFF, 16'h0084, 0, 64'h1234, 16'h0, 0, 0, 64'h8000_0001, 0,
                  1, 64'h2, 64'h4000, 64'hFFFF_FFFF, 64'h1800, 64'h8000_0000);
    tbl[2]  = mkv(64'h5000, 32'h73, 16'h0800, 0, 64'h99, 16'h0080, 64'h80, 64'h8, 64'h1000, 0,
                  1, 64'h8000_0000_0000_0007, 64'h5000, 0, 64'h1880, 64'h1000);
    tbl[3]  = mkv(64'h6000, 32'h3020_0073, 16'h0, 1, 0, 16'h0, 0, 64'h80, 64'h1000, 64'h8000_0203,
                  2, 0, 0, 0, 64'h1888, 64'h8000_0200);
    tbl[4]  = mkv(64'h6100, 32'h0, 16'h4400, 0, 0, 16'h0, 0, 64'h8, 64'h1000, 0,
                  0, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(64'h6200, 32'h0, 16'h0, 0, 0, 16'h0800, 64'h800, 64'h0, 64'h1000, 0,
                  0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(64'h7000, 32'h0, 16'h0020, 0, 64'hDEAD_BEEF_0000_0010, 16'h0, 0, 64'h1800, 64'h2000, 0,
                  1, 64'h5, 64'h7000, 64'hDEAD_BEEF_0000_0010, 64'h1800, 64'h2000);
    tbl[7]  = mkv(64'h7100, 32'h0, 16'h1002, 0, 64'h55, 16'h0, 0, 64'h0, 64'h2000, 0,
                  1, 64'hC, 64'h7100, 64'h7100, 64'h1800, 64'h2000);
    tbl[8]  = mkv(64'h7200, 32'h0, 16'h100B, 0, 64'h55, 16'h0, 0, 64'h0, 64'h2000, 0,
                  1, 64'h3, 64'h7200, 0, 64'h1800, 64'h2000);
    tbl[9]  = mkv(64'h7300, 32'h0, 16'h0800, 1, 0, 16'h0, 0, 64'h88, 64'h2000, 64'h9000,
                  1, 64'hB, 64'h7300, 0, 64'h1880, 64'h2000);
    tbl[10] = mkv(64'h7400, 32'h0, 16'h0, 0, 0, 16'h0008, 64'hFFFF, 64'h8, 64'h2003, 0,
                  1, 64'h8000_0000_0000_0003, 64'h7400, 0, 64'h1880, 64'h2000);
    tbl[11] = mkv(64'h7500, 32'h0, 16'h0004, 0, 0, 16'h8001, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hA000_0000_0000_0008, 64'h101, 0,
                  1, 64'h8000_0000_0000_000F, 64'h7500, 0, 64'hA000_0000_0000_1880, 64'h13C);
    tbl[12] = mkv(64'h7600, 32'h0, 16'h0, 1, 0, 16'hFFFF, 64'h0, 64'h1808, 64'h2000, 64'h123,
                  2, 0, 0, 0, 64'h1880, 64'h120);

    repeat (2) @(negedge clk);
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_write_data", mcause_wd | mepc_wd | mtval_wd | mstatus_wd, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(tbl[i], i % 3, 1'b0);

    // Fetch stalls the redirect for five cycles.
    run_vec(tbl[0], 5, 1'b0);
    // Commit keeps presenting a trapping instruction while busy.
    run_vec(tbl[1], 2, 1'b1);

    // Reset asserted while waiting in REDIRECT.
    apply(tbl[0]);
    commit_valid = 1'b1;
    @(posedge clk); #1;
    commit_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_redirect_valid", redirect_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_csr_wen", csr_wen, 0);
    chk("arst_flush", flush, 0);
    chk("arst_busy", busy, 0);
    chk("arst_redirect_valid", redirect_valid, 0);
    chk("arst_redirect_pc", redirect_pc, 0);
    chk("arst_mcause", mcause_wd, 0);
    chk("arst_mepc", mepc_wd, 0);
    chk("arst_mtval", mtval_wd, 0);
    chk("arst_mstatus", mstatus_wd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_csr_wen", csr_wen, 0);
      chk("post_rst_redirect_valid", redirect_valid, 0);
    end

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.pc = {$urandom, $urandom};
      v.inst = $urandom;
      v.excp = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
      v.mret = 1'($urandom_range(0, 1));
      v.addr = {$urandom, $urandom};
      v.irq = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom & $urandom);
      v.mie = {$urandom, $urandom};
      v.mstatus = {$urandom, $urandom};
      v.mtvec = {$urandom, $urandom};
      v.mepc = {$urandom, $urandom};
      v = model(v);
      run_vec(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
